// File: rtl/sync_fifo_ram_if.sv
// Producer/consumer side of the single-clock FIFO: write/read requests, clear,
// show-ahead head word, occupancy count and flow-control flags.
interface sync_fifo_ram_if #(
   parameter int AW = 5,
   parameter int DW = 65
);
   logic          clear;
   logic          wr_en;
   logic [DW-1:0] din;
   logic          rd_en;
   logic [DW-1:0] dout;
   logic          empty;
   logic          full;
   logic          almost_empty;
   logic          almost_full;
   logic [AW:0]   count;

   modport master (
      output clear, wr_en, din, rd_en,
      input  dout, empty, full, almost_empty, almost_full, count
   );

   modport slave (
      input  clear, wr_en, din, rd_en,
      output dout, empty, full, almost_empty, almost_full, count
   );
endinterface

// File: rtl/sync_fifo_ram.sv
// Single-clock show-ahead FIFO: AW+1-bit pointers, DEPTH x DW dual-port RAM,
// exact full/empty and one-from-boundary almost flags decoded from the pointers.
module sync_fifo_ram #(
   parameter int AW = 5,
   parameter int DW = 65
) (
   input  logic            clk,
   input  logic            rst_n,
   sync_fifo_ram_if.slave  bus
);
   localparam int          DEPTH     = 1 << AW;
   localparam logic [AW:0] ONE       = (AW+1)'(1);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] DEPTH_M1  = (AW+1)'(DEPTH - 1);

   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_dout;

   logic [AW:0]   w_count;
   logic [AW:0]   w_wptr_nxt;
   logic [AW:0]   w_rptr_nxt;
   logic [AW-1:0] w_wr_addr;
   logic [AW-1:0] w_rd_addr_nxt;
   logic          w_empty;
   logic          w_full;
   logic          w_wallow;
   logic          w_rallow;
   logic          w_wr_commit;
   logic          w_bypass;

   // Occupancy is the pointer difference; the extra MSB separates full from empty.
   assign w_count  = r_wptr - r_rptr;
   assign w_empty  = (w_count == '0);
   assign w_full   = (w_count == DEPTH_CNT);

   assign w_wallow    = bus.wr_en & ~w_full;
   assign w_rallow    = bus.rd_en & ~w_empty;
   assign w_wr_commit = w_wallow & ~bus.clear;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_wptr_nxt = r_wptr;
      w_rptr_nxt = r_rptr;
      if (bus.clear) begin
         w_wptr_nxt = '0;
         w_rptr_nxt = '0;
      end else begin
         if (w_wallow) w_wptr_nxt = r_wptr + ONE;
         if (w_rallow) w_rptr_nxt = r_rptr + ONE;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         r_wptr <= w_wptr_nxt;
         r_rptr <= w_rptr_nxt;
      end
   end

   assign w_wr_addr     = r_wptr[AW-1:0];
   assign w_rd_addr_nxt = w_rptr_nxt[AW-1:0];

   // The only way the next head can equal the slot being written is when that
   // write becomes the sole stored word, so forward din instead of stale RAM.
   assign w_bypass = w_wr_commit & (w_wr_addr == w_rd_addr_nxt);

   // NOTE: the RAM array and its read register have no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (w_wr_commit) r_mem[w_wr_addr] <= bus.din;
      if (w_bypass) r_dout <= bus.din;
      else          r_dout <= r_mem[w_rd_addr_nxt];
   end

   assign bus.dout         = r_dout;
   assign bus.empty        = w_empty;
   assign bus.full         = w_full;
   assign bus.almost_empty = (w_count == ONE);
   assign bus.almost_full  = (w_count == DEPTH_M1);
   assign bus.count        = w_count;

   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) w_count <= DEPTH_CNT);
   a_flags_excl  : assert property (@(posedge clk) disable iff (!rst_n) !(w_empty && w_full));
endmodule

// File: tb/tb_sync_fifo_ram.sv
// Scoreboard bench for sync_fifo_ram: stimulus pushes expected pops into a queue,
// a negedge monitor compares each popped head word, and flags are checked per cycle.
module tb_sync_fifo_ram;
   localparam int AW    = 5;
   localparam int DW    = 65;
   localparam int DEPTH = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_ram_if #(.AW(AW), .DW(DW)) bus ();

   sync_fifo_ram #(.AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [DW-1:0] model_q [$];
   logic [DW-1:0] exp_q   [$];
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Flags, count and head word against the reference queue.
   task automatic check_state();
      int n = model_q.size();
      check("count",        DW'(bus.count),        DW'(n));
      check("empty",        DW'(bus.empty),        DW'(n == 0));
      check("full",         DW'(bus.full),         DW'(n == DEPTH));
      check("almost_empty", DW'(bus.almost_empty), DW'(n == 1));
      check("almost_full",  DW'(bus.almost_full),  DW'(n == DEPTH - 1));
      if (n > 0) check("head", bus.dout, model_q[0]);
   endtask

   // Called 1 time unit after a rising edge: drives one cycle of requests.
   task automatic drive(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
      bit ra;
      bit wa;
      bus.wr_en = wr;
      bus.din   = d;
      bus.rd_en = rd;
      bus.clear = clr;
      ra = rd && (model_q.size() > 0);
      wa = wr && (model_q.size() < DEPTH);
      if (clr) begin
         model_q.delete();
      end else begin
         if (ra) exp_q.push_back(model_q.pop_front());
         if (wa) model_q.push_back(d);
      end
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.clear = 1'b0;
      check_state();
   endtask

   // Monitor: whenever the DUT will pop at the coming edge, its head must match the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.rd_en && !bus.clear && !bus.empty) begin
         if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL pop_unexpected @%0t: got %h expected no pop", $time, bus.dout);
         end else begin
            check("pop_data", bus.dout, exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.clear = 1'b0;
      bus.din   = '0;

      // Reset held for 4 cycles, then first write on the first edge with rst_n high.
      repeat (4) @(posedge clk);
      #1;
      check_state();
      rst_n = 1'b1;
      drive(1'b1, 65'h1_0000_0000_0000_00AA, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);

      // Fill to full, then one write that must be ignored.
      for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
      drive(1'b1, DW'(99), 1'b0, 1'b0);

      // Drain in order, then one read that must be ignored.
      for (int i = 0; i <= DEPTH; i++) drive(1'b0, '0, 1'b1, 1'b0);

      // Simultaneous read/write at count 5, long enough to wrap the pointers.
      for (int i = 0; i < 5; i++) drive(1'b1, DW'(100 + i), 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) drive(1'b1, DW'(200 + i), 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 1'b0);

      // Full with both requests: read wins, write dropped.
      for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(300 + i), 1'b0, 1'b0);
      drive(1'b1, 65'h0_0000_0000_0000_DEAD, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, '0, 1'b1, 1'b0);

      // Empty with both requests: write wins and falls through to dout.
      drive(1'b1, 65'h1_0000_0000_0000_BEEF, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset mid-cycle at count 17.
      for (int i = 0; i < 17; i++) drive(1'b1, DW'(400 + i), 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_q.delete();
      check_state();
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_state();

      // Clear at count 17 with a simultaneous write: everything discarded.
      for (int i = 0; i < 17; i++) drive(1'b1, DW'(500 + i), 1'b0, 1'b0);
      drive(1'b1, 65'h0_0000_0000_0000_0777, 1'b0, 1'b1);
      drive(1'b1, 65'h1_0000_0000_0000_0055, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);

      check("scoreboard_left", DW'(exp_q.size()), DW'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
